// File: rtl/clkdiv_adda_prog.sv
// clkdiv_adda_prog: multi-channel programmable clock divider for the AD/DA
// sampling path. Each channel divides hclkin by a runtime-loadable ratio and
// drives a registered divided clock plus single-cycle rise/fall strobes.
// Ratio changes land only on a period boundary; sync_req re-phases every
// channel together.
//
// Ports:
//   hclkin     source clock, all logic on its rising edge
//   reset      asynchronous active-high reset
//   cfg_valid  config request valid
//   cfg_ready  config slot free (no ratio pending on any channel)
//   cfg_ch     target channel of the config request
//   cfg_div    requested ratio (0 and 1 are stored as 2)
//   sync_req   one-cycle pulse, restart all channels at phase 0
//   clkout     divided clocks, bit i = channel i
//   rise_stb   pulse in the first high cycle of clkout[i]
//   fall_stb   pulse in the first low cycle of clkout[i]
//   busy       a pending config is not yet applied
//
// Optional build macro CLKDIV_ADDA_PROG_GATE_EN adds input ch_en[CH]: a
// disabled channel parks at the end of its period with clkout low, and
// restarts with a clean rising edge when re-enabled.
module clkdiv_adda_prog #(
    parameter int  CH          = 2,
    parameter int  DIV_W       = 16,
    parameter int  DEFAULT_DIV = 4,
    localparam int CW          = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             hclkin,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CW-1:0]    cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             sync_req,
`ifdef CLKDIV_ADDA_PROG_GATE_EN
    input  logic [CH-1:0]    ch_en,
`endif
    output logic [CH-1:0]    clkout,
    output logic [CH-1:0]    rise_stb,
    output logic [CH-1:0]    fall_stb,
    output logic             busy
);

    typedef logic [DIV_W-1:0] div_t;

    localparam div_t DEF_DIV = div_t'(DEFAULT_DIV);
    localparam div_t ONE     = div_t'(1);
    localparam div_t TWO     = div_t'(2);

    div_t div_q      [CH];
    div_t div_d      [CH];
    div_t cnt_q      [CH];
    div_t cnt_d      [CH];
    div_t pend_div_q [CH];
    div_t pend_div_d [CH];

    div_t half_c [CH];
    div_t last_c [CH];
    div_t nxt_c  [CH];

    logic [CH-1:0] wrap_c;
    logic [CH-1:0] pend_vld_q, pend_vld_d;
    logic [CH-1:0] clkout_q, clkout_d;
    logic [CH-1:0] rise_q, rise_d;
    logic [CH-1:0] fall_q, fall_d;
    logic [CH-1:0] en;

    logic xfer;
    div_t cfg_div_c;

`ifdef CLKDIV_ADDA_PROG_GATE_EN
    assign en = ch_en;
`else
    assign en = '1;
`endif

    // A single global slot: nothing new is taken while any channel waits.
    assign cfg_ready = ~|pend_vld_q;
    assign busy      = |pend_vld_q;
    assign xfer      = cfg_valid & cfg_ready;

    // Ratios below 2 would stall or pass hclkin straight through.
    assign cfg_div_c = (cfg_div < TWO) ? TWO : cfg_div;

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            half_c[i] = div_q[i] - (div_q[i] >> 1);
            last_c[i] = div_q[i] - ONE;
            wrap_c[i] = (cnt_q[i] == last_c[i]);
            nxt_c[i]  = wrap_c[i] ? '0 : cnt_q[i] + ONE;
        end
    end

    always_comb begin
        pend_vld_d = pend_vld_q;
        clkout_d   = '0;
        rise_d     = '0;
        fall_d     = '0;
        for (int i = 0; i < CH; i++) begin
            div_d[i]      = div_q[i];
            cnt_d[i]      = cnt_q[i];
            pend_div_d[i] = pend_div_q[i];

            if (!en[i]) begin
                // Parked at D-1 so the first enabled edge wraps to phase 0.
                if (pend_vld_q[i]) begin
                    div_d[i]      = pend_div_q[i];
                    cnt_d[i]      = pend_div_q[i] - ONE;
                    pend_vld_d[i] = 1'b0;
                end else begin
                    cnt_d[i] = last_c[i];
                end
            end else if (sync_req) begin
                cnt_d[i]    = '0;
                clkout_d[i] = 1'b1;
                rise_d[i]   = 1'b1;
                if (pend_vld_q[i]) begin
                    div_d[i]      = pend_div_q[i];
                    pend_vld_d[i] = 1'b0;
                end
            end else begin
                // Outputs for this edge still use the old ratio; a new one
                // only governs counting from the next cycle on.
                cnt_d[i]    = nxt_c[i];
                clkout_d[i] = (nxt_c[i] < half_c[i]);
                rise_d[i]   = (nxt_c[i] == '0);
                fall_d[i]   = (nxt_c[i] == half_c[i]);
                if (wrap_c[i] && pend_vld_q[i]) begin
                    div_d[i]      = pend_div_q[i];
                    pend_vld_d[i] = 1'b0;
                end
            end

            // Out-of-range channel indices match no channel and are dropped.
            if (xfer && (cfg_ch == CW'(i))) begin
                pend_vld_d[i] = 1'b1;
                pend_div_d[i] = cfg_div_c;
            end
        end
    end

    always_ff @(posedge hclkin or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CH; i++) begin
                div_q[i]      <= DEF_DIV;
                cnt_q[i]      <= DEF_DIV - ONE;
                pend_div_q[i] <= TWO;
            end
            pend_vld_q <= '0;
            clkout_q   <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                div_q[i]      <= div_d[i];
                cnt_q[i]      <= cnt_d[i];
                pend_div_q[i] <= pend_div_d[i];
            end
            pend_vld_q <= pend_vld_d;
            clkout_q   <= clkout_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
        end
    end

    assign clkout   = clkout_q;
    assign rise_stb = rise_q;
    assign fall_stb = fall_q;

endmodule

// File: tb/tb_clkdiv_adda_prog.sv
// tb_clkdiv_adda_prog: scoreboard bench for clkdiv_adda_prog with CH=2.
// Per-cycle expectations are written as phase letters R/H/F/L per channel.
module tb_clkdiv_adda_prog;

    localparam int CH          = 2;
    localparam int DIV_W       = 16;
    localparam int DEFAULT_DIV = 4;

    logic             hclkin    = 1'b0;
    logic             reset     = 1'b1;
    logic             cfg_valid = 1'b0;
    logic [0:0]       cfg_ch    = 1'b0;
    logic [DIV_W-1:0] cfg_div   = '0;
    logic             sync_req  = 1'b0;
    logic             cfg_ready;
    logic             busy;
    logic [CH-1:0]    clkout;
    logic [CH-1:0]    rise_stb;
    logic [CH-1:0]    fall_stb;
`ifdef CLKDIV_ADDA_PROG_GATE_EN
    logic [CH-1:0]    ch_en = '1;
`endif

    clkdiv_adda_prog #(
        .CH          (CH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .hclkin    (hclkin),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .sync_req  (sync_req),
`ifdef CLKDIV_ADDA_PROG_GATE_EN
        .ch_en     (ch_en),
`endif
        .clkout    (clkout),
        .rise_stb  (rise_stb),
        .fall_stb  (fall_stb),
        .busy      (busy)
    );

    always #5 hclkin = ~hclkin;

    typedef struct {
        int            cyc;
        logic [CH-1:0] clk;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
        logic          rdy;
        logic          bsy;
        string         tag;
    } exp_t;

    exp_t sbq[$];
    int   ncyc   = 0;
    int   checks = 0;
    int   errors = 0;

    string P2 = "RF";
    string P3 = "RHF";
    string P4 = "RHFL";
    string P5 = "RHHFL";
    string P6 = "RHHFLL";

    always @(posedge hclkin) ncyc++;

    function automatic logic [2:0] dec(input byte c);
        // {clk, rise, fall}
        case (c)
            "R":     return 3'b110;
            "H":     return 3'b100;
            "F":     return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // Push the expectation for the next edge, then advance past it.
    task automatic tick(input byte c0, input byte c1, input bit rdy,
                        input string tag, input bit rst_after = 1'b0);
        exp_t e;
        logic [2:0] d0, d1;
        d0 = dec(c0);
        d1 = dec(c1);
        e.cyc  = ncyc + 1;
        e.clk  = {d1[2], d0[2]};
        e.rise = {d1[1], d0[1]};
        e.fall = {d1[0], d0[0]};
        e.rdy  = rdy;
        e.bsy  = ~rdy;
        e.tag  = tag;
        sbq.push_back(e);
        @(posedge hclkin);
        #1;
        if (rst_after) reset = 1'b1;
    endtask

    task automatic cfg(input bit ch, input int dv);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = DIV_W'(dv);
    endtask

    // Monitor: compare every queued expectation on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge hclkin);
            while (sbq.size() > 0 && sbq[0].cyc <= ncyc) begin
                e = sbq.pop_front();
                checks++;
                if (e.cyc != ncyc) begin
                    errors++;
                    $display("FAIL %s: stale entry cyc=%0d now=%0d",
                             e.tag, e.cyc, ncyc);
                end else if (clkout !== e.clk || rise_stb !== e.rise ||
                             fall_stb !== e.fall || cfg_ready !== e.rdy ||
                             busy !== e.bsy) begin
                    errors++;
                    $display({"FAIL %s cyc=%0d: got clk=%b rise=%b fall=%b",
                              " rdy=%b busy=%b, want clk=%b rise=%b fall=%b",
                              " rdy=%b busy=%b"},
                             e.tag, ncyc, clkout, rise_stb, fall_stb,
                             cfg_ready, busy, e.clk, e.rise, e.fall,
                             e.rdy, e.bsy);
                end
            end
        end
    end

    initial begin
        // Reset held: all outputs low, slot free.
        repeat (3) tick("L", "L", 1'b1, "reset");
        reset = 1'b0;

        // 1: default ratio 4 on both channels.
        for (int i = 0; i < 16; i++)
            tick(P4[i%4], P4[i%4], 1'b1, "t1_default");

        // 2: ch1 -> 5, accepted at cnt=1, applied at the next wrap.
        tick("R", "R", 1'b1, "t2_pre");
        tick("H", "H", 1'b1, "t2_pre");
        cfg(1'b1, 5);
        tick("F", "F", 1'b0, "t2_accept");
        cfg_valid = 1'b0;
        tick("L", "L", 1'b0, "t2_wait");
        tick("R", "R", 1'b1, "t2_apply");
        for (int i = 1; i < 20; i++)
            tick(P4[i%4], P5[i%5], 1'b1, "t2_div5");

        // 3: ch0 cfg_div=0 accepted on a wrap edge, so waits a period.
        cfg(1'b0, 0);
        tick("R", "R", 1'b0, "t3_accept_on_wrap");
        cfg_valid = 1'b0;
        tick("H", "H", 1'b0, "t3_wait");
        tick("F", "H", 1'b0, "t3_wait");
        tick("L", "F", 1'b0, "t3_wait");
        tick("R", "L", 1'b1, "t3_apply");
        for (int k = 1; k < 16; k++) begin
            if (k == 3) cfg(1'b0, 1);
            tick(P2[k%2], P5[(k+4)%5], (k != 3), "t3_div2");
            cfg_valid = 1'b0;
        end

        // 6: cfg_valid held across two requests; second stalls.
        cfg(1'b0, 4);
        tick("R", "R", 1'b0, "t6_first");
        cfg(1'b1, 6);
        tick("F", "H", 1'b0, "t6_stall");
        tick("R", "H", 1'b1, "t6_apply0");
        tick("H", "F", 1'b0, "t6_second");
        cfg_valid = 1'b0;
        tick("F", "L", 1'b0, "t6_wait");
        tick("L", "R", 1'b1, "t6_apply1");
        for (int i = 0; i < 4; i++)
            tick(P4[i], P6[i+1], 1'b1, "t6_phase");

        // 4: sync re-phases D=4 and D=6; rises coincide every 12.
        sync_req = 1'b1;
        tick("R", "R", 1'b1, "t4_sync");
        sync_req = 1'b0;
        for (int i = 1; i <= 24; i++)
            tick(P4[i%4], P6[i%6], 1'b1, "t4_aligned");

        // Sync applies a pending ratio at once (ch0 -> 3).
        cfg(1'b0, 3);
        tick("H", "H", 1'b0, "t4_pend");
        cfg_valid = 1'b0;
        sync_req  = 1'b1;
        tick("R", "R", 1'b1, "t4_sync_apply");
        sync_req = 1'b0;
        for (int i = 1; i <= 8; i++)
            tick(P3[i%3], P6[i%6], 1'b1, "t4_div3");

        // 5: reset before the wrap drops clkout at once and the config.
        cfg(1'b1, 7);
        tick("R", "F", 1'b0, "t5_accept");
        cfg_valid = 1'b0;
        tick("L", "L", 1'b1, "t5_async_rst", 1'b1);
        tick("L", "L", 1'b1, "t5_in_rst");
        reset = 1'b0;
        for (int i = 0; i < 8; i++)
            tick(P4[i%4], P4[i%4], 1'b1, "t5_default");

        @(negedge hclkin);
        #1;
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, want 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
